// File: rtl/cxl_mem_req_engine_if.sv
// CPI A2F/F2A signal bundle between a CXL.mem agent and the request engine.
// The engine connects through the slave modport and the agent through the master modport.
interface cxl_mem_req_engine_if #(
  parameter int DATA_W = 128
);
  logic              a2f_txcon_req;
  logic              a2f_rxcon_ack;
  logic              a2f_req_is_valid;
  logic [3:0]        a2f_req_protocol_id;
  logic [128:0]      a2f_req_header;
  logic              a2f_req_crd_rtn;
  logic              a2f_data_is_valid;
  logic [DATA_W-1:0] a2f_data_body;
  logic [3:0]        a2f_data_byte_en;
  logic              a2f_data_poison;
  logic              f2a_rsp_is_valid;
  logic [3:0]        f2a_rsp_protocol_id;
  logic [128:0]      f2a_rsp_header;
  logic              f2a_data_is_valid;
  logic [3:0]        f2a_data_protocol_id;
  logic [127:0]      f2a_data_header;
  logic [DATA_W-1:0] f2a_data_body;
  logic              f2a_data_parity;
  logic              f2a_data_eop;
  logic              f2a_rsp_excrd_valid;

  modport master (
    output a2f_txcon_req, a2f_req_is_valid, a2f_req_protocol_id, a2f_req_header,
           a2f_data_is_valid, a2f_data_body, a2f_data_byte_en, a2f_data_poison,
           f2a_rsp_excrd_valid,
    input  a2f_rxcon_ack, a2f_req_crd_rtn, f2a_rsp_is_valid, f2a_rsp_protocol_id,
           f2a_rsp_header, f2a_data_is_valid, f2a_data_protocol_id, f2a_data_header,
           f2a_data_body, f2a_data_parity, f2a_data_eop
  );

  modport slave (
    input  a2f_txcon_req, a2f_req_is_valid, a2f_req_protocol_id, a2f_req_header,
           a2f_data_is_valid, a2f_data_body, a2f_data_byte_en, a2f_data_poison,
           f2a_rsp_excrd_valid,
    output a2f_rxcon_ack, a2f_req_crd_rtn, f2a_rsp_is_valid, f2a_rsp_protocol_id,
           f2a_rsp_header, f2a_data_is_valid, f2a_data_protocol_id, f2a_data_header,
           f2a_data_body, f2a_data_parity, f2a_data_eop
  );
endinterface

// File: rtl/cxl_mem_req_engine.sv
// CXL.mem request engine: queues MemRd/MemWr, accesses device RAM (read-merge-write
// for dword enables) and returns F2A read data or NDR responses under F2A credit.
module cxl_mem_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         ovf
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign ovf     = push && !do_push;
  assign dout    = mem[rd_ptr];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: storage carries no reset; count/pointers are reset, so stale words are never read as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module cxl_mem_req_engine #(
  parameter int         ADDR_W    = 10,
  parameter int         DATA_W    = 128,
  parameter int         REQ_DEPTH = 4,
  parameter int         CRD_INIT  = 4,
  parameter logic [3:0] PROTO_ID  = 4'h2
) (
  input  logic                  fm_clk,
  input  logic                  fm_rst,
  cxl_mem_req_engine_if.slave   bus,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  err_ovf
);
  localparam int DWORD_W = DATA_W / 4;
  localparam int CNT_W   = $clog2(CRD_INIT + 1);

  // Field order mirrors header bits [ADDR_W+12:0] so an entry is a straight slice.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [11:0]       tag;
    logic              wr;
  } req_t;

  typedef struct packed {
    logic              poison;
    logic [3:0]        byte_en;
    logic [DATA_W-1:0] body;
  } wdat_t;

  typedef enum logic [2:0] {IDLE, RD, WAIT, SEND_DATA, MERGE, SEND_RSP} state_t;

  state_t            state;
  req_t              req_head, cur_req;
  wdat_t             dat_head, cur_dat;
  logic              req_push, req_pop, req_empty, req_ovf;
  logic              dat_push, dat_pop, dat_empty, dat_ovf;
  logic              start, crd_dec;
  logic [CNT_W-1:0]  crd_cnt;
  logic              rx_ack, crd_rtn;
  logic              rsp_valid, data_valid, data_parity;
  logic [11:0]       rsp_tag, data_tag;
  logic [1:0]        rsp_status;
  logic [DATA_W-1:0] data_body, merged;
  logic              unused_hdr;

  assign unused_hdr = ^bus.a2f_req_header[128:ADDR_W+13];

  assign req_push = rx_ack && bus.a2f_req_is_valid && (bus.a2f_req_protocol_id == PROTO_ID);
  assign dat_push = rx_ack && bus.a2f_data_is_valid;

  cxl_mem_req_fifo #(.W($bits(req_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk(fm_clk), .rst_n(fm_rst), .push(req_push),
    .din(req_t'(bus.a2f_req_header[ADDR_W+12:0])),
    .pop(req_pop), .dout(req_head), .empty(req_empty), .ovf(req_ovf)
  );

  cxl_mem_req_fifo #(.W($bits(wdat_t)), .DEPTH(REQ_DEPTH)) u_dat_fifo (
    .clk(fm_clk), .rst_n(fm_rst), .push(dat_push),
    .din({bus.a2f_data_poison, bus.a2f_data_byte_en, bus.a2f_data_body}),
    .pop(dat_pop), .dout(dat_head), .empty(dat_empty), .ovf(dat_ovf)
  );

  // A write cannot start until its data beat has arrived.
  assign start   = (state == IDLE) && !req_empty && (crd_cnt != '0) &&
                   (!req_head.wr || !dat_empty);
  assign req_pop = start;
  assign dat_pop = start && req_head.wr;
  assign crd_dec = rsp_valid || data_valid;

  // NOTE: default assignment first, so every path assigns merged and no latch is inferred.
  always_comb begin
    merged = mem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (cur_dat.byte_en[i]) merged[i*DWORD_W +: DWORD_W] = cur_dat.body[i*DWORD_W +: DWORD_W];
    end
  end

  always_ff @(posedge fm_clk or negedge fm_rst) begin
    if (!fm_rst) begin
      crd_cnt <= CNT_W'(CRD_INIT);
    end else if (crd_dec && !bus.f2a_rsp_excrd_valid) begin
      crd_cnt <= crd_cnt - CNT_W'(1);
    end else if (!crd_dec && bus.f2a_rsp_excrd_valid && crd_cnt != CNT_W'(CRD_INIT)) begin
      crd_cnt <= crd_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge fm_clk or negedge fm_rst) begin
    if (!fm_rst) begin
      state       <= IDLE;
      rx_ack      <= 1'b0;
      crd_rtn     <= 1'b0;
      err_ovf     <= 1'b0;
      cur_req     <= '0;
      cur_dat     <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rsp_valid   <= 1'b0;
      rsp_tag     <= '0;
      rsp_status  <= '0;
      data_valid  <= 1'b0;
      data_tag    <= '0;
      data_body   <= '0;
      data_parity <= 1'b0;
    end else begin
      rx_ack  <= bus.a2f_txcon_req;
      crd_rtn <= req_pop;
      err_ovf <= err_ovf || req_ovf || dat_ovf;
      case (state)
        IDLE: if (start) begin
          cur_req  <= req_head;
          if (req_head.wr) cur_dat <= dat_head;
          mem_addr <= req_head.addr;
          state    <= RD;
        end
        RD: state <= WAIT;
        WAIT: begin
          if (cur_req.wr) begin
            mem_we    <= !cur_dat.poison;
            mem_wdata <= merged;
            state     <= MERGE;
          end else begin
            data_valid  <= 1'b1;
            data_tag    <= cur_req.tag;
            data_body   <= mem_rdata;
            data_parity <= ^mem_rdata;
            state       <= SEND_DATA;
          end
        end
        SEND_DATA: begin
          data_valid  <= 1'b0;
          data_tag    <= '0;
          data_body   <= '0;
          data_parity <= 1'b0;
          state       <= IDLE;
        end
        MERGE: begin
          mem_we     <= 1'b0;
          rsp_valid  <= 1'b1;
          rsp_tag    <= cur_req.tag;
          rsp_status <= {1'b0, cur_dat.poison};
          state      <= SEND_RSP;
        end
        SEND_RSP: begin
          rsp_valid  <= 1'b0;
          rsp_tag    <= '0;
          rsp_status <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a2f_rxcon_ack        = rx_ack;
  assign bus.a2f_req_crd_rtn      = crd_rtn;
  assign bus.f2a_rsp_is_valid     = rsp_valid;
  assign bus.f2a_rsp_protocol_id  = rsp_valid ? PROTO_ID : 4'h0;
  assign bus.f2a_rsp_header       = {{(129-14){1'b0}}, rsp_status, rsp_tag};
  assign bus.f2a_data_is_valid    = data_valid;
  assign bus.f2a_data_protocol_id = data_valid ? PROTO_ID : 4'h0;
  assign bus.f2a_data_header      = {{(128-12){1'b0}}, data_tag};
  assign bus.f2a_data_body        = data_body;
  assign bus.f2a_data_parity      = data_parity;
  assign bus.f2a_data_eop         = data_valid;
endmodule

// File: tb/tb_cxl_mem_req_engine.sv
// Scoreboard bench for cxl_mem_req_engine: directed requests push expected F2A
// outputs, a negedge monitor pops and compares each one the engine presents.
module tb_cxl_mem_req_engine;
  localparam int         ADDR_W    = 10;
  localparam int         DATA_W    = 128;
  localparam int         REQ_DEPTH = 4;
  localparam int         CRD_INIT  = 2;
  localparam logic [3:0] PROTO_ID  = 4'h2;

  localparam logic [DATA_W-1:0] ALL_A  = {4{32'hAAAA_AAAA}};
  localparam logic [DATA_W-1:0] ALL_1  = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] MERGED = 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0000;

  typedef struct {
    logic              is_data;
    logic [11:0]       tag;
    logic [1:0]        status;
    logic [DATA_W-1:0] body;
    int                exp_cyc;
  } exp_t;

  logic fm_clk = 1'b0;
  logic fm_rst = 1'b0;
  always #5 fm_clk = ~fm_clk;

  cxl_mem_req_engine_if #(.DATA_W(DATA_W)) bus ();
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              err_ovf;

  cxl_mem_req_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REQ_DEPTH(REQ_DEPTH),
    .CRD_INIT(CRD_INIT), .PROTO_ID(PROTO_ID)
  ) dut (
    .fm_clk(fm_clk), .fm_rst(fm_rst), .bus(bus),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_ovf(err_ovf)
  );

  logic [DATA_W-1:0] ram [1 << ADDR_W];
  always @(posedge fm_clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  exp_t sb[$];
  int   n_vec = 0, n_miss = 0;
  int   cyc = 0, n_out = 0, n_we = 0, n_crd_rtn = 0;
  logic auto_rtn = 1'b0;

  always @(posedge fm_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [128:0] act, input logic [128:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Agent side: hand back one credit for every F2A output while auto return is on.
  always @(negedge fm_clk) begin
    if (auto_rtn) bus.f2a_rsp_excrd_valid = bus.f2a_rsp_is_valid || bus.f2a_data_is_valid;
  end

  always @(negedge fm_clk) begin : monitor
    exp_t e;
    if (fm_rst) begin
      if (bus.a2f_req_crd_rtn) n_crd_rtn++;
      if (mem_we) n_we++;
      if (bus.f2a_data_is_valid || bus.f2a_rsp_is_valid) begin
        n_out++;
        if (sb.size() == 0) begin
          check("unexpected_output", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check("out_kind", bus.f2a_data_is_valid, e.is_data);
          if (e.exp_cyc >= 0) check("out_latency", cyc, e.exp_cyc);
          if (e.is_data) begin
            check("data_header", bus.f2a_data_header, {116'b0, e.tag});
            check("data_body", bus.f2a_data_body, e.body);
            check("data_parity", bus.f2a_data_parity, ^e.body);
            check("data_eop", bus.f2a_data_eop, 1'b1);
            check("data_proto", bus.f2a_data_protocol_id, PROTO_ID);
          end else begin
            check("rsp_header", bus.f2a_rsp_header, {115'b0, e.status, e.tag});
            check("rsp_proto", bus.f2a_rsp_protocol_id, PROTO_ID);
          end
        end
      end
    end
  end

  task automatic expect_data(input logic [11:0] tag, input logic [DATA_W-1:0] body, input int at);
    exp_t e;
    e.is_data = 1'b1; e.tag = tag; e.status = 2'b00; e.body = body; e.exp_cyc = at;
    sb.push_back(e);
  endtask

  task automatic expect_rsp(input logic [11:0] tag, input logic [1:0] status, input int at);
    exp_t e;
    e.is_data = 1'b0; e.tag = tag; e.status = status; e.body = '0; e.exp_cyc = at;
    sb.push_back(e);
  endtask

  // n is the number of the rising edge that samples the request.
  task automatic send(input logic wr, input logic [11:0] tag, input logic [ADDR_W-1:0] addr,
                      input logic [3:0] proto, input logic with_data,
                      input logic [DATA_W-1:0] body, input logic [3:0] be,
                      input logic poison, output int n);
    logic [128:0] hdr;
    hdr = '0;
    hdr[0] = wr;
    hdr[12:1] = tag;
    hdr[ADDR_W+12:13] = addr;
    @(negedge fm_clk);
    n = cyc + 1;
    bus.a2f_req_is_valid    = 1'b1;
    bus.a2f_req_protocol_id = proto;
    bus.a2f_req_header      = hdr;
    if (with_data) begin
      bus.a2f_data_is_valid = 1'b1;
      bus.a2f_data_body     = body;
      bus.a2f_data_byte_en  = be;
      bus.a2f_data_poison   = poison;
    end
    @(negedge fm_clk);
    bus.a2f_req_is_valid  = 1'b0;
    bus.a2f_data_is_valid = 1'b0;
  endtask

  task automatic send_data(input logic [DATA_W-1:0] body, input logic [3:0] be,
                           input logic poison, output int n);
    @(negedge fm_clk);
    n = cyc + 1;
    bus.a2f_data_is_valid = 1'b1;
    bus.a2f_data_body     = body;
    bus.a2f_data_byte_en  = be;
    bus.a2f_data_poison   = poison;
    @(negedge fm_clk);
    bus.a2f_data_is_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge fm_clk);
      k++;
    end
    if (sb.size() != 0) begin
      check({name, "_timeout"}, sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge fm_clk);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 30000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n, nd, base, we0;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
    bus.a2f_txcon_req       = 1'b0;
    bus.a2f_req_is_valid    = 1'b0;
    bus.a2f_req_protocol_id = 4'h0;
    bus.a2f_req_header      = '0;
    bus.a2f_data_is_valid   = 1'b0;
    bus.a2f_data_body       = '0;
    bus.a2f_data_byte_en    = 4'h0;
    bus.a2f_data_poison     = 1'b0;
    bus.f2a_rsp_excrd_valid = 1'b0;

    repeat (3) @(negedge fm_clk);
    check("rst_ack", bus.a2f_rxcon_ack, 1'b0);
    check("rst_outputs", {bus.f2a_rsp_is_valid, bus.f2a_data_is_valid, mem_we,
                          bus.a2f_req_crd_rtn, err_ovf}, 5'b0);
    check("rst_rsp_header", bus.f2a_rsp_header, '0);
    fm_rst = 1'b1;

    @(negedge fm_clk);
    bus.a2f_txcon_req = 1'b1;
    @(negedge fm_clk);
    check("connect_ack", bus.a2f_rxcon_ack, 1'b1);
    auto_rtn = 1'b1;

    // Full-dword write, then read it back at minimum latency.
    send(1'b1, 12'h005, 10'h010, PROTO_ID, 1'b1, ALL_A, 4'hF, 1'b0, n);
    expect_rsp(12'h005, 2'b00, n + 4);
    wait_drain("wr_full");
    check("wr_full_we_count", n_we, 1);
    check("wr_full_ram", ram[10'h010], ALL_A);
    send(1'b0, 12'h006, 10'h010, PROTO_ID, 1'b0, '0, 4'h0, 1'b0, n);
    expect_data(12'h006, ALL_A, n + 3);
    wait_drain("rd_full");

    // Header ahead of its data: the NDR is timed from the data beat.
    send(1'b1, 12'h007, 10'h020, PROTO_ID, 1'b0, '0, 4'h0, 1'b0, n);
    repeat (3) @(negedge fm_clk);
    send_data('0, 4'hF, 1'b0, nd);
    expect_rsp(12'h007, 2'b00, nd + 4);
    wait_drain("wr_late_data");

    // Partial write followed back-to-back by a read of the merged word.
    send(1'b1, 12'h008, 10'h020, PROTO_ID, 1'b1, ALL_1, 4'b0010, 1'b0, n);
    expect_rsp(12'h008, 2'b00, n + 4);
    send(1'b0, 12'h009, 10'h020, PROTO_ID, 1'b0, '0, 4'h0, 1'b0, n);
    expect_data(12'h009, MERGED, -1);
    wait_drain("wr_partial");
    check("wr_partial_we_count", n_we, 3);

    // Poisoned write: status 01, RAM untouched.
    we0 = n_we;
    send(1'b1, 12'h00A, 10'h010, PROTO_ID, 1'b1, '0, 4'hF, 1'b1, n);
    expect_rsp(12'h00A, 2'b01, n + 4);
    wait_drain("wr_poison");
    check("wr_poison_no_we", n_we, we0);
    send(1'b0, 12'h00B, 10'h010, PROTO_ID, 1'b0, '0, 4'h0, 1'b0, n);
    expect_data(12'h00B, ALL_A, n + 3);
    wait_drain("rd_after_poison");

    // Foreign protocol id is ignored.
    base = n_out;
    send(1'b0, 12'h00C, 10'h010, 4'h1, 1'b0, '0, 4'h0, 1'b0, n);
    repeat (10) @(negedge fm_clk);
    check("bad_proto_no_output", n_out, base);
    check("crd_rtn_count", n_crd_rtn, 7);

    // Credit starvation: only CRD_INIT outputs until the agent returns one.
    auto_rtn = 1'b0;
    bus.f2a_rsp_excrd_valid = 1'b0;
    base = n_out;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 12'h010 + 12'(i), 10'h020, PROTO_ID, 1'b0, '0, 4'h0, 1'b0, n);
      expect_data(12'h010 + 12'(i), MERGED, -1);
    end
    repeat (30) @(negedge fm_clk);
    check("crd_starved_outputs", n_out - base, 2);
    check("crd_starved_pending", sb.size(), 1);
    bus.f2a_rsp_excrd_valid = 1'b1;
    @(negedge fm_clk);
    bus.f2a_rsp_excrd_valid = 1'b0;
    wait_drain("crd_return");
    check("crd_after_return", n_out - base, 3);

    // Credits now exhausted: fill the request FIFO and overflow it.
    base = n_out;
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 12'h020 + 12'(i), 10'h010, PROTO_ID, 1'b0, '0, 4'h0, 1'b0, n);
      if (i == 3) check("ovf_not_yet", err_ovf, 1'b0);
    end
    check("ovf_set", err_ovf, 1'b1);
    repeat (10) @(negedge fm_clk);
    check("ovf_no_output", n_out, base);
    fm_rst = 1'b0;
    @(negedge fm_clk);
    check("ovf_cleared_by_reset", err_ovf, 1'b0);
    fm_rst = 1'b1;
    auto_rtn = 1'b1;
    repeat (2) @(negedge fm_clk);
    send(1'b0, 12'h030, 10'h020, PROTO_ID, 1'b0, '0, 4'h0, 1'b0, n);
    expect_data(12'h030, MERGED, n + 3);
    wait_drain("rd_after_reset");

    // Disconnect mid-op: the op completes, later pushes are refused.
    send(1'b0, 12'h031, 10'h010, PROTO_ID, 1'b0, '0, 4'h0, 1'b0, n);
    expect_data(12'h031, ALL_A, n + 3);
    bus.a2f_txcon_req = 1'b0;
    wait_drain("rd_disconnect");
    check("disconnect_ack", bus.a2f_rxcon_ack, 1'b0);
    base = n_out;
    send(1'b0, 12'h032, 10'h010, PROTO_ID, 1'b0, '0, 4'h0, 1'b0, n);
    repeat (10) @(negedge fm_clk);
    check("disconnect_no_push", n_out, base);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
